core_boot_mem: RTL and testbench

Memory responder and program loader on the far side of the core's instruction and data ports. After reset it accepts a little-endian byte stream on a valid/ready load port and packs it into word storage. When the stream ends it pulses `start` to the core. It then serves instruction fetches and data loads/stores for the running core.

---
 rtl/core_pkg.sv | 15 +
 rtl/core_mem_array.sv | 33 +++
 rtl/core_boot_mem.sv | 123 ++++++++++++
 tb/tb_core_boot_mem.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the boot loader / memory responder.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } boot_st_t;

  localparam int DEF_DEPTH = 1024;
  localparam int DEF_AW    = 10;
  localparam int LANES     = 4;

endpackage

// File: rtl/core_mem_array.sv
// DEPTH x 32 word storage: two combinational read ports, one byte-enabled write port.
module core_mem_array
  import core_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LANES-1:0] be,
  input  logic [31:0]      wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [31:0]      rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [31:0]      rdata_b
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset, so a loaded image survives a core reset and maps to plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/core_boot_mem.sv
// Byte-stream program loader followed by instruction/data memory service for the core.
module core_boot_mem
  import core_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        start,
  output logic        running,
  input  logic [31:0] instr_addr,
  output logic [31:0] instruction,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata
);

  boot_st_t      state;
  logic [1:0]    lane;
  logic [AW-1:0] ptr;
  logic [23:0]   asm_q;
  logic          start_q;

  logic          accept;
  logic          ld_flush;
  logic [31:0]   ld_word;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[31:AW+2], instr_addr[1:0],
                              data_addr[31:AW+2], data_addr[1:0]};

  assign ld_ready = (state == IDLE) || (state == LOAD);
  assign accept   = ld_valid && ld_ready;
  assign ld_flush = accept && (ld_last || (lane == 2'd3));
  assign start    = start_q;
  assign running  = (state == RUN);

  // Word being flushed: assembled lower lanes, the incoming byte, zeros above it.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ld_word = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      if (2'(i) < lane) ld_word[8*i +: 8] = asm_q[8*i +: 8];
    end
    ld_word[{lane, 3'b000} +: 8] = ld_byte;
  end

  always_comb begin
    if (state == RUN) begin
      mem_we    = data_wen;
      mem_waddr = data_addr[AW+1:2];
      mem_be    = data_be;
      mem_wdata = data_wdata;
    end else begin
      mem_we    = ld_flush;
      mem_waddr = ptr;
      mem_be    = 4'hF;
      mem_wdata = ld_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      lane    <= '0;
      ptr     <= '0;
      asm_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (ld_last) begin
              state   <= START;
              start_q <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        START:   state <= RUN;
        default: state <= RUN;
      endcase

      if (accept) begin
        if (ld_flush) begin
          lane <= '0;
          ptr  <= ld_last ? '0 : ptr + 1'b1;
        end else begin
          asm_q[{lane, 3'b000} +: 8] <= ld_byte;
          lane <= lane + 2'd1;
        end
      end
    end
  end

  core_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .be      (mem_be),
    .wdata   (mem_wdata),
    .raddr_a (instr_addr[AW+1:2]),
    .rdata_a (instruction),
    .raddr_b (data_addr[AW+1:2]),
    .rdata_b (data_rdata)
  );

endmodule

// File: tb/tb_core_boot_mem.sv
// Scoreboard bench for core_boot_mem: stimulus queues expectations, a negedge monitor checks them.
module tb_core_boot_mem;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk;
  logic        rstn;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        start;
  logic        running;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic [31:0] data_addr;
  logic        data_wen;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  core_boot_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .start       (start),
    .running     (running),
    .instr_addr  (instr_addr),
    .instruction (instruction),
    .data_addr   (data_addr),
    .data_wen    (data_wen),
    .data_be     (data_be),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_INSTR, K_DATA, K_START, K_RUNNING, K_READY, K_LANE} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: all outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_INSTR:   act = instruction;
        K_DATA:    act = data_rdata;
        K_START:   act = {31'd0, start};
        K_RUNNING: act = {31'd0, running};
        K_READY:   act = {31'd0, ld_ready};
        default:   act = {30'd0, dut.lane};
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic expect_val(input kind_e k, input string name, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.name = name;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Lets the monitor consume everything queued; a stuck queue is reported and flushed.
  task automatic drain();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      check("drain", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    next_cycle();
  endtask

  // Streams bytes back to back; the final one carries ld_last when with_last is set.
  task automatic load(input logic [7:0] img[$], input bit with_last);
    for (int i = 0; i < img.size(); i++) begin
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = with_last && (i == img.size() - 1);
      next_cycle();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    data_addr  = a;
    data_be    = be;
    data_wdata = d;
    data_wen   = 1'b1;
    next_cycle();
    data_wen   = 1'b0;
  endtask

  // Checks the cycle right after the last byte and the one after that.
  task automatic check_start_seq(input string tag, input logic [31:0] word0);
    instr_addr = 32'h0;
    expect_val(K_START,   {tag, "_start_hi"}, 1);
    expect_val(K_READY,   {tag, "_ready_lo"}, 0);
    expect_val(K_RUNNING, {tag, "_run_lo"},   0);
    expect_val(K_INSTR,   {tag, "_fetch0"},   word0);
    drain();
    next_cycle();
    expect_val(K_START,   {tag, "_start_lo"}, 0);
    expect_val(K_RUNNING, {tag, "_run_hi"},   1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img[$];
    rstn = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    instr_addr = '0; data_addr = '0; data_wen = 1'b0; data_be = '0; data_wdata = '0;
    next_cycle();
    rstn = 1'b1;
    expect_val(K_READY,   "rst_ready", 1);
    expect_val(K_START,   "rst_start", 0);
    expect_val(K_RUNNING, "rst_run",   0);
    drain();

    // Single-word image.
    img = '{8'h13, 8'h05, 8'hA0, 8'h00};
    load(img, 1'b1);
    check_start_seq("t1", 32'h00A00513);
    store(32'h14, 4'hF, 32'h1111_1111);
    expect_val(K_DATA, "t1_word5", 32'h1111_1111);
    drain();

    // Six-byte image with a short final word, and a stray store during LOAD.
    do_reset();
    data_addr = 32'h14; data_be = 4'hF; data_wdata = 32'hDEAD_BEEF; data_wen = 1'b1;
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load(img, 1'b1);
    data_wen = 1'b0;
    check_start_seq("t2", 32'h0403_0201);
    data_addr = 32'h04;
    expect_val(K_DATA, "t2_word1", 32'h0000_0605);
    drain();
    data_addr = 32'h14;
    expect_val(K_DATA, "t2_load_store_ignored", 32'h1111_1111);
    drain();

    // Byte-enabled store, read-during-write and address aliasing.
    store(32'h08, 4'hF, 32'hFFFF_FFFF);
    data_addr = 32'h0B; data_be = 4'b1000; data_wdata = 32'h1234_5678; data_wen = 1'b1;
    instr_addr = 32'h08;
    expect_val(K_DATA,  "t3_rdw_old_data",  32'hFFFF_FFFF);
    expect_val(K_INSTR, "t3_rdw_old_instr", 32'hFFFF_FFFF);
    drain();
    next_cycle();
    data_wen = 1'b0;
    data_addr = 32'h08;
    instr_addr = 32'h08 + 4 * DEPTH;
    expect_val(K_DATA,  "t3_be_store", 32'h12FF_FFFF);
    expect_val(K_INSTR, "t3_alias",    32'h12FF_FFFF);
    drain();
    store(32'h08, 4'h0, 32'h0000_0000);
    expect_val(K_DATA, "t3_be_zero_noop", 32'h12FF_FFFF);
    drain();

    // Loader input while running is refused.
    ld_valid = 1'b1; ld_byte = 8'h77; ld_last = 1'b1;
    expect_val(K_READY, "t3_run_ready_lo", 0);
    drain();
    next_cycle();
    ld_valid = 1'b0; ld_last = 1'b0;
    data_addr = 32'h00; instr_addr = 32'h04;
    expect_val(K_START, "t3_run_no_start", 0);
    expect_val(K_DATA,  "t3_run_word0",    32'h0403_0201);
    expect_val(K_INSTR, "t3_run_word1",    32'h0000_0605);
    drain();

    // Reset in the middle of a word, then reload.
    do_reset();
    img = '{8'h11, 8'h22};
    load(img, 1'b0);
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    expect_val(K_START,   "t4_start0", 0);
    expect_val(K_RUNNING, "t4_run0",   0);
    expect_val(K_LANE,    "t4_lane0",  0);
    expect_val(K_READY,   "t4_ready1", 1);
    drain();
    next_cycle();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(img, 1'b1);
    check_start_seq("t4", 32'hDDCC_BBAA);
    data_addr = 32'h04;
    expect_val(K_DATA, "t4_word1_kept", 32'h0000_0605);
    drain();

    // DEPTH+1 words: the last word wraps onto word 0.
    do_reset();
    img.delete();
    for (int w = 0; w <= DEPTH; w++) begin
      img.push_back(8'(w));
      img.push_back(8'h11);
      img.push_back(8'h22);
      img.push_back(8'hA5);
    end
    load(img, 1'b1);
    check_start_seq("t5", 32'hA522_1110);
    data_addr = 32'h04; instr_addr = 32'h3C;
    expect_val(K_DATA,  "t5_word1",  32'hA522_1101);
    expect_val(K_INSTR, "t5_word15", 32'hA522_110F);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
